// File: rtl/tone_channels.sv
// Multi-channel square-wave tone generator on the peripheral strobe bus.
// Each channel has a half-period, a tick-timed duration with auto-stop, and a done/irq flag.
module tone_channels #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned PERIOD_WIDTH   = 16,
    parameter int unsigned DURATION_WIDTH = 16,
    parameter int unsigned TICK_DIV       = 12000
) (
    input  logic                raw_clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                write_enable,
    input  logic [7:0]          address,
    input  logic [31:0]         data_in,
    output logic [31:0]         data_out,
    output logic [CHANNELS-1:0] tone_p,
    output logic [CHANNELS-1:0] tone_m,
    output logic                irq
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [5:0]          word;
    logic [3:0]          sel_ch;
    logic [1:0]          sel_reg;
    logic [PW-1:0]       presc_q;
    logic                tick;
    logic [31:0]         rdata;
    logic [31:0]         ch_rdata [CHANNELS];
    logic [CHANNELS-1:0] done_irq;
    logic                unused_bus;

    assign word       = address[7:2];
    assign sel_ch     = word[5:2];
    assign sel_reg    = word[1:0];
    assign unused_bus = ^{data_in, address[1:0]};

    // Shared prescaler; tick marks the wrap cycle.
    assign tick = (presc_q == PW'(TICK_DIV - 1));

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            presc_q <= '0;
        end else begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic                      hit;
        logic                      wr_period, wr_duration, wr_control, wr_status;
        logic                      expire, sounding;
        logic [PERIOD_WIDTH-1:0]   period_q, period_eff, count_q;
        logic [DURATION_WIDTH-1:0] duration_q, remain_q;
        logic                      active_q, phase_q, done_q, irq_en_q;
        logic [31:0]               rd_word;

        assign hit         = write_enable && (sel_ch == 4'(c));
        assign wr_period   = hit && (sel_reg == 2'd0);
        assign wr_duration = hit && (sel_reg == 2'd1);
        assign wr_control  = hit && (sel_reg == 2'd2);
        assign wr_status   = hit && (sel_reg == 2'd3);

        // A PERIOD write is compared against the running counter in the same cycle.
        assign period_eff = wr_period ? data_in[PERIOD_WIDTH-1:0] : period_q;
        assign expire     = tick && active_q && (duration_q != '0) &&
                            (remain_q <= DURATION_WIDTH'(1));
        assign sounding   = active_q && (period_q != '0);

        always_ff @(posedge raw_clk or negedge reset) begin
            if (!reset) begin
                period_q   <= '0;
                duration_q <= '0;
                count_q    <= '0;
                remain_q   <= '0;
                active_q   <= 1'b0;
                phase_q    <= 1'b0;
                done_q     <= 1'b0;
                irq_en_q   <= 1'b0;
            end else begin
                if (wr_period) period_q <= data_in[PERIOD_WIDTH-1:0];
                if (wr_duration) duration_q <= data_in[DURATION_WIDTH-1:0];
                if (wr_control) begin
                    // Control write overrides a coinciding expiry.
                    irq_en_q <= data_in[1];
                    active_q <= data_in[0];
                    count_q  <= '0;
                    phase_q  <= 1'b0;
                    remain_q <= duration_q;
                    if (data_in[0]) done_q <= 1'b0;
                end else begin
                    if (expire) begin
                        active_q <= 1'b0;
                        done_q   <= 1'b1;
                    end else if (wr_status && data_in[1]) begin
                        done_q <= 1'b0;
                    end
                    if (tick && active_q && (duration_q != '0) && (remain_q != '0)) begin
                        remain_q <= remain_q - 1'b1;
                    end
                    if (!active_q || (period_eff == '0)) begin
                        count_q <= '0;
                    end else if (count_q >= period_eff) begin
                        count_q <= '0;
                        phase_q <= ~phase_q;
                    end else begin
                        count_q <= count_q + 1'b1;
                    end
                end
            end
        end

        always_comb begin
            rd_word = '0;
            unique case (sel_reg)
                2'd0: rd_word[PERIOD_WIDTH-1:0]   = period_q;
                2'd1: rd_word[DURATION_WIDTH-1:0] = duration_q;
                2'd2: rd_word[1:0]                = {irq_en_q, active_q};
                2'd3: rd_word[1:0]                = {done_q, active_q};
                default: rd_word = '0;
            endcase
        end

        assign ch_rdata[c] = rd_word;
        assign done_irq[c] = done_q && irq_en_q;
        assign tone_p[c]   = sounding && phase_q;
        assign tone_m[c]   = sounding && !phase_q;
    end

    always_comb begin
        rdata = '0;
        if (word == 6'd63) begin
            rdata = 32'(done_irq);
        end else begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                if (sel_ch == 4'(i)) rdata = ch_rdata[i];
            end
        end
    end

    always_ff @(posedge raw_clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            irq      <= 1'b0;
        end else begin
            if (enable && !write_enable) data_out <= rdata;
            irq <= |done_irq;
        end
    end

endmodule

// File: tb/tb_tone_channels.sv
// Directed bench for tone_channels with TICK_DIV=10; every check is an immediate assertion.
module tb_tone_channels;

    logic        raw_clk = 1'b0;
    logic        reset = 1'b0;
    logic        enable = 1'b0;
    logic        write_enable = 1'b0;
    logic [7:0]  address = '0;
    logic [31:0] data_in = '0;
    logic [31:0] data_out;
    logic [3:0]  tone_p, tone_m;
    logic        irq;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int s_edge;
    logic [31:0] rv;
    logic ph;

    tone_channels #(
        .CHANNELS(4),
        .PERIOD_WIDTH(16),
        .DURATION_WIDTH(16),
        .TICK_DIV(10)
    ) dut (
        .raw_clk(raw_clk),
        .reset(reset),
        .enable(enable),
        .write_enable(write_enable),
        .address(address),
        .data_in(data_in),
        .data_out(data_out),
        .tone_p(tone_p),
        .tone_m(tone_m),
        .irq(irq)
    );

    always #5 raw_clk = ~raw_clk;

    // Edge count since first reset release; prescaler value equals cyc mod 10.
    always @(posedge raw_clk) if (reset) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Both bus tasks are entered at a negedge and consume exactly one rising edge.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        address = a;
        data_in = d;
        write_enable = 1'b1;
        @(negedge raw_clk);
        write_enable = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        address = a;
        enable = 1'b1;
        @(negedge raw_clk);
        enable = 1'b0;
        d = data_out;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge raw_clk);
        chk("rst_tone_p", 32'(tone_p), 32'h0);
        chk("rst_tone_m", 32'(tone_m), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_data_out", data_out, 32'h0);
        reset = 1'b1;

        // Bus: upper bits masked, unmapped word reads 0
        wr(8'h00, 32'hFFFF_1234);
        rd(8'h00, rv);
        chk("rd_period0", rv, 32'h0000_1234);
        rd(8'hF0, rv);
        chk("rd_unmapped", rv, 32'h0);

        // Frequency: half-period of 4 cycles on channel 0 only
        wr(8'h00, 32'd3);
        wr(8'h08, 32'h1);
        for (int i = 0; i < 12; i++) begin
            ph = ((i / 4) % 2) == 1;
            chk("freq", 32'({tone_p, tone_m}), 32'({3'b0, ph, 3'b0, ~ph}));
            @(negedge raw_clk);
        end
        wr(8'h08, 32'h0);
        chk("stop", 32'({tone_p, tone_m}), 32'h0);

        // Duration and irq on channel 1
        wr(8'h10, 32'd5);
        wr(8'h14, 32'd3);
        wr(8'h18, 32'd3);
        rd(8'h1C, rv);
        chk("dur_active", rv, 32'h1);
        repeat (35) @(negedge raw_clk);
        chk("dur_irq", 32'(irq), 32'h1);
        chk("dur_silent", 32'({tone_p, tone_m}), 32'h0);
        rd(8'h1C, rv);
        chk("dur_status", rv, 32'h2);
        rd(8'hFC, rv);
        chk("dur_global", rv, 32'h2);
        wr(8'h1C, 32'h2);
        @(negedge raw_clk);
        chk("irq_clear", 32'(irq), 32'h0);
        rd(8'h1C, rv);
        chk("status_cleared", rv, 32'h0);

        // PERIOD shrink on channel 2
        wr(8'h20, 32'd100);
        wr(8'h28, 32'h1);
        repeat (20) @(negedge raw_clk);
        wr(8'h20, 32'd10);
        chk("shrink_toggle", 32'(tone_p[2]), 32'h1);
        repeat (10) @(negedge raw_clk);
        chk("shrink_hold", 32'(tone_p[2]), 32'h1);
        @(negedge raw_clk);
        chk("shrink_half", 32'(tone_p[2]), 32'h0);
        wr(8'h28, 32'h0);

        // Collision: restart channel 0 on its expiry tick
        wr(8'h04, 32'd2);
        while (((cyc + 1) % 10) != 1) @(negedge raw_clk);
        s_edge = cyc + 1;
        wr(8'h08, 32'h1);
        repeat (18) @(negedge raw_clk);
        wr(8'h08, 32'h1);
        rd(8'h0C, rv);
        chk("collide_status", rv, 32'h1);
        while (cyc < s_edge + 38) @(negedge raw_clk);
        rd(8'h0C, rv);
        chk("collide_full", rv, 32'h1);
        rd(8'h0C, rv);
        chk("collide_expire", rv, 32'h2);

        // Reset mid-tone
        wr(8'h34, 32'd1);
        wr(8'h38, 32'h3);
        wr(8'h04, 32'd0);
        wr(8'h08, 32'h1);
        repeat (12) @(negedge raw_clk);
        chk("pre_reset_irq", 32'(irq), 32'h1);
        rd(8'h00, rv);
        chk("pre_reset_period", rv, 32'd3);
        for (int k = 0; k < 10 && !tone_p[0]; k++) @(negedge raw_clk);
        chk("pre_reset_tone", 32'(tone_p[0]), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("async_tone_p", 32'(tone_p), 32'h0);
        chk("async_tone_m", 32'(tone_m), 32'h0);
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_data_out", data_out, 32'h0);
        #1 reset = 1'b1;
        @(negedge raw_clk);
        rd(8'h0C, rv);
        chk("post_reset_status0", rv, 32'h0);
        rd(8'h00, rv);
        chk("post_reset_period0", rv, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
